sat_narrow: RTL and testbench

//   Reverse of the immediate sign-extender. Narrows a 32-bit datapath value to 16 bits

---
 rtl/sat_narrow.sv | 99 +++++++++
 tb/tb_sat_narrow.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/sat_narrow.sv
// sat_narrow: 2-stage valid/ready pipeline narrowing IN_W to OUT_W bits with signed/unsigned saturation.
// Optional saturating overflow counter (ovf_clr/ovf_cnt) when SAT_OVF_CNT_EN is defined.
module sat_narrow #(
    parameter int IN_W  = 32,
    parameter int OUT_W = 16,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    input  logic             in_unsigned,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_ovf
`ifdef SAT_OVF_CNT_EN
    ,
    input  logic             ovf_clr,
    output logic [CNT_W-1:0] ovf_cnt
`endif
);

    if (IN_W <= OUT_W || CNT_W < 1) begin : g_bad_params
        $error("sat_narrow: IN_W must exceed OUT_W and CNT_W must be positive");
    end

    logic              s1_valid_q, s1_valid_d, s1_uns_q, s1_uns_d;
    logic [IN_W-1:0]   s1_data_q, s1_data_d;
    logic              s2_valid_q, s2_valid_d, s2_ovf_q, s2_ovf_d;
    logic [OUT_W-1:0]  s2_data_q, s2_data_d;
    logic              s2_load, in_fire, out_fire, sat_ovf;
    logic [OUT_W-1:0]  sat_data;
    logic [IN_W-OUT_W:0]   sign_bits;
    logic [IN_W-OUT_W-1:0] high_bits;

    always_comb begin
        sign_bits  = s1_data_q[IN_W-1:OUT_W-1];
        high_bits  = s1_data_q[IN_W-1:OUT_W];
        // signed value fits only when the dropped bits plus the new sign bit all agree
        sat_ovf    = s1_uns_q ? |high_bits : !(&sign_bits || ~|sign_bits);
        sat_data   = !sat_ovf ? s1_data_q[OUT_W-1:0] :
                     s1_uns_q ? {OUT_W{1'b1}} :
                     s1_data_q[IN_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
        s2_load    = s1_valid_q && (!s2_valid_q || out_ready);
        in_ready   = !s1_valid_q || s2_load;
        in_fire    = in_valid && in_ready;
        out_fire   = s2_valid_q && out_ready;
        s1_valid_d = in_fire ? 1'b1 : s2_load ? 1'b0 : s1_valid_q;
        s1_data_d  = in_fire ? in_data : s1_data_q;
        s1_uns_d   = in_fire ? in_unsigned : s1_uns_q;
        s2_valid_d = s2_load ? 1'b1 : out_fire ? 1'b0 : s2_valid_q;
        s2_data_d  = s2_load ? sat_data : s2_data_q;
        s2_ovf_d   = s2_load ? sat_ovf : s2_ovf_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_uns_q   <= 1'b0;
            s1_data_q  <= '0;
            s2_valid_q <= 1'b0;
            s2_ovf_q   <= 1'b0;
            s2_data_q  <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_uns_q   <= s1_uns_d;
            s1_data_q  <= s1_data_d;
            s2_valid_q <= s2_valid_d;
            s2_ovf_q   <= s2_ovf_d;
            s2_data_q  <= s2_data_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign out_data  = s2_data_q;
    assign out_ovf   = s2_ovf_q;

`ifdef SAT_OVF_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             cnt_evt;

    // a clear coinciding with a counted event restarts at 1 so that event is kept
    always_comb begin
        cnt_evt = out_fire && s2_ovf_q;
        cnt_d   = ovf_clr ? {{(CNT_W-1){1'b0}}, cnt_evt} :
                  (cnt_evt && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign ovf_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_sat_narrow.sv
// tb_sat_narrow: randomized scoreboard bench for sat_narrow against an arithmetic saturation model.
module tb_sat_narrow;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0, in_unsigned = 1'b0, out_ready = 1'b0, ovf_clr = 1'b0;
    logic [31:0] in_data = '0;
    logic        in_ready, out_valid, out_ovf;
    logic [15:0] out_data;
`ifdef SAT_OVF_CNT_EN
    logic [1:0]  ovf_cnt;
`endif

    int n_cmp = 0, n_err = 0, n_in = 0, n_out = 0;
    logic [16:0] exp_q[$];
    logic [32:0] in_q[$];

    always #5 clk = ~clk;

    sat_narrow #(.IN_W(32), .OUT_W(16), .CNT_W(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_unsigned(in_unsigned),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ovf(out_ovf)
`ifdef SAT_OVF_CNT_EN
        , .ovf_clr(ovf_clr), .ovf_cnt(ovf_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // range check on the true numeric value, returns {ovf, result}
    function automatic logic [16:0] ref_sat(input logic [31:0] d, input logic u);
        longint v;
        v = u ? longint'({32'b0, d}) : longint'($signed(d));
        if (u && v > 65535)  return {1'b1, 16'hFFFF};
        if (!u && v > 32767)  return {1'b1, 16'h7FFF};
        if (!u && v < -32768) return {1'b1, 16'h8000};
        return {1'b0, d[15:0]};
    endfunction

    function automatic logic [31:0] rnd_data();
        logic [31:0] d;
        d = $urandom >> $urandom_range(0, 31);
        return $urandom_range(0, 1) ? -d : d;
    endfunction

    // drive one cycle's inputs at negedge, then score any transfers happening at the next posedge
    task automatic step(input logic v, input logic [31:0] d, input logic u, input logic r, input logic c);
        logic [16:0] e;
        logic [32:0] i;
        logic [31:0] ext;
        @(negedge clk);
        in_valid = v; in_data = d; in_unsigned = u; out_ready = r; ovf_clr = c;
        #1;
        if (out_valid && out_ready) begin
            n_out++;
            if (exp_q.size() == 0) chk("spurious_out", 32'(out_valid), 32'd0);
            else begin
                e = exp_q.pop_front();
                i = in_q.pop_front();
                chk("out_data", 32'(out_data), 32'(e[15:0]));
                chk("out_ovf", 32'(out_ovf), 32'(e[16]));
                ext = i[32] ? {16'b0, out_data} : {{16{out_data[15]}}, out_data};
                if (!out_ovf) chk("round_trip", ext, i[31:0]);
            end
        end
        if (v && in_ready) begin
            n_in++;
            exp_q.push_back(ref_sat(d, u));
            in_q.push_back({u, d});
        end
    endtask

    task automatic drain();
        for (int k = 0; k < 50 && exp_q.size() != 0; k++) step(0, 0, 0, 1, 0);
        chk("drain_left", exp_q.size(), 0);
        step(0, 0, 0, 1, 0);
    endtask

    task automatic directed(input logic [31:0] d, input logic u, input logic [15:0] eo, input logic ev);
        step(1, d, u, 1, 0);
        step(0, 0, 0, 1, 0);
        chk("lat1_valid", 32'(out_valid), 0);
        step(0, 0, 0, 1, 0);
        chk("lat2_valid", 32'(out_valid), 1);
        chk("dir_data", 32'(out_data), 32'(eo));
        chk("dir_ovf", 32'(out_ovf), 32'(ev));
    endtask

    initial begin
        logic [31:0] vals[8];
        logic [15:0] held;
        int acc, base, j, bound, sent;
        #22;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_data", 32'(out_data), 0);
        chk("rst_out_ovf", 32'(out_ovf), 0);
        @(negedge clk); rst_n = 1'b1;
        step(0, 0, 0, 1, 0);
        chk("rst_in_ready", 32'(in_ready), 1);

        directed(32'h00007FFF, 0, 16'h7FFF, 0);
        directed(32'hFFFF8000, 0, 16'h8000, 0);
        directed(32'h00008000, 0, 16'h7FFF, 1);
        directed(32'h80000000, 0, 16'h8000, 1);
        directed(32'hFFFF7FFF, 0, 16'h8000, 1);
        directed(32'h0000FFFF, 1, 16'hFFFF, 0);
        directed(32'h00010000, 1, 16'hFFFF, 1);
        directed(32'hFFFFFFFF, 1, 16'hFFFF, 1);
        directed(32'h00001234, 1, 16'h1234, 0);
        drain();

        // backpressure: 5 stalled cycles, then release
        for (int k = 0; k < 8; k++) vals[k] = rnd_data();
        base = n_out; acc = n_in; j = 0; held = '0;
        for (int c = 0; c < 5; c++) begin
            step(1, vals[j], 0, 0, 0);
            if (n_in != acc + j) j++;
            if (c == 2) held = out_data;
            if (c > 2) chk("stall_hold", 32'(out_data), 32'(held));
        end
        chk("bp_accepts", j, 2);
        chk("bp_in_ready", 32'(in_ready), 0);
        for (int k = 0; k < 100 && j < 8; k++) begin
            step(1, vals[j], 0, 1, 0);
            if (n_in != acc + j) j++;
        end
        chk("bp_all_sent", j, 8);
        drain();
        chk("bp_out_count", n_out - base, 8);

        // random backpressure, 200 transfers
        base = n_out; bound = 0;
        while (n_out - base < 200 && bound < 5000) begin
            step($urandom_range(0, 9) < 7, rnd_data(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
            bound++;
        end
        chk("rand_timeout", 32'(bound >= 5000), 0);
        drain();

        // round trip: 1000 values at full rate
        sent = 0;
        for (int k = 0; k < 3000 && sent < 1000; k++) begin
            acc = n_in;
            step(1, rnd_data(), 1'($urandom_range(0, 1)), 1, 0);
            if (n_in != acc) sent++;
        end
        chk("rt_sent", sent, 1000);
        drain();

        // reset with both stages full
        step(1, 32'h11112222, 0, 0, 0);
        step(1, 32'h00000042, 0, 0, 0);
        step(1, 32'h00000043, 0, 0, 0);
        chk("pre_rst_valid", 32'(out_valid), 1);
        #2 rst_n = 1'b0;
        #1 chk("async_rst_valid", 32'(out_valid), 0);
        chk("async_rst_data", 32'(out_data), 0);
        exp_q.delete(); in_q.delete();
        in_valid = 1'b0;
        @(negedge clk); @(negedge clk); rst_n = 1'b1;
        step(1, 32'h00001234, 0, 1, 0);
        step(0, 0, 0, 1, 0);
        chk("post_rst_empty", 32'(out_valid), 0);
        step(0, 0, 0, 1, 0);
        chk("post_rst_valid", 32'(out_valid), 1);
        chk("post_rst_first", 32'(out_data), 32'h1234);
        drain();

`ifdef SAT_OVF_CNT_EN
        chk("cnt_zero", 32'(ovf_cnt), 0);
        for (int k = 0; k < 5; k++) step(1, 32'h00010000, 1, 1, 0);
        drain();
        chk("cnt_sat", 32'(ovf_cnt), 3);
        step(1, 32'h00020000, 1, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 1);
        step(0, 0, 0, 1, 0);
        chk("cnt_clr_evt", 32'(ovf_cnt), 1);
        step(0, 0, 0, 1, 1);
        step(0, 0, 0, 1, 0);
        chk("cnt_clr", 32'(ovf_cnt), 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
